// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO PHY responder: state encoding, opcodes and frame layout.
package mdio_pkg;

    typedef enum logic [6:0] {
        IDLE   = 7'b000_0001,
        ST     = 7'b000_0010,
        HDR    = 7'b000_0100,
        WDATA  = 7'b000_1000,
        RDATA  = 7'b001_0000,
        ERR    = 7'b010_0000,
        IGNORE = 7'b100_0000
    } mdio_state_e;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] ST_CODE  = 2'b01;

    localparam int FRAME_LEN = 32;
    localparam int DATA_W    = 16;
    localparam int HDR_LEN   = FRAME_LEN - DATA_W;
    localparam int ADDR_W    = 5;
    localparam int REG_N     = 32;

    // Field positions within the 32-bit frame (MSB first on the wire)
    localparam int ST_HI    = 31;
    localparam int OP_HI    = 29;
    localparam int PHYAD_HI = 27;
    localparam int REGAD_HI = 22;
    localparam int TA_HI    = 17;
    localparam int DATA_HI  = 15;

endpackage

// File: rtl/mdio_phy_responder_if.sv
// MDIO bus bundle between the transaction generator (master) and the PHY responder (slave).
interface mdio_phy_responder_if;

    logic mdc;
    logic mdio_out;
    logic mdio_oe;
    logic mdio_in;
    logic mdio_in_oe;

    modport master (
        output mdc,
        output mdio_out,
        output mdio_oe,
        input  mdio_in,
        input  mdio_in_oe
    );

    modport slave (
        input  mdc,
        input  mdio_out,
        input  mdio_oe,
        output mdio_in,
        output mdio_in_oe
    );

endinterface

// File: rtl/mdio_regfile.sv
// 32x16 register file: async reset to REG_RST, one synchronous write port, two combinational read ports.
module mdio_regfile
    import mdio_pkg::*;
#(
    parameter logic [DATA_W-1:0] REG_RST = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] frame_addr,
    output logic [DATA_W-1:0] frame_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [REG_N];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < REG_N; i++) begin
                mem[i] <= REG_RST;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign frame_data = mem[frame_addr];
    assign dbg_data   = mem[dbg_addr];

endmodule

// File: rtl/mdio_phy_responder.sv
// PHY-side MDIO responder: samples the generator's MDC/MDIO in the clk domain and serves register reads/writes.
// Optional MDIO_PHYAD_MATCH_EN: answer only frames whose PHYAD equals PHY_ADDR; others are silently ignored.
module mdio_phy_responder
    import mdio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PHY_ADDR = 5'd1,
    parameter logic [DATA_W-1:0] REG_RST  = 16'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    mdio_phy_responder_if.slave  mdio,
    output logic                 wr_stb,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 frame_err,
    output logic                 busy,
    input  logic [ADDR_W-1:0]    dbg_addr,
    output logic [DATA_W-1:0]    dbg_data
);

`ifdef MDIO_PHYAD_MATCH_EN
    localparam bit PHYAD_MATCH = 1'b1;
`else
    localparam bit PHYAD_MATCH = 1'b0;
`endif

    mdio_state_e       state;
    logic              mdc_q;
    logic [5:0]        count;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] sh_next;
    logic [ADDR_W-1:0] regad;
    logic [DATA_W-1:0] rd_shift;
    logic              rd_load;
    logic              in_oe;
    logic [DATA_W-1:0] frame_rdata;
    logic              rise;
    logic              fall;
    logic [1:0]        hdr_op;
    logic [ADDR_W-1:0] hdr_phyad;
    logic [ADDR_W-1:0] hdr_regad;
    logic              phyad_hit;

    assign rise = mdio.mdc & ~mdc_q;
    assign fall = ~mdio.mdc & mdc_q;

    // Header fields are decoded from the shifter value including the bit sampled this cycle
    assign sh_next   = {shreg[DATA_W-2:0], mdio.mdio_out};
    assign hdr_op    = sh_next[OP_HI-DATA_W -: 2];
    assign hdr_phyad = sh_next[PHYAD_HI-DATA_W -: ADDR_W];
    assign hdr_regad = sh_next[REGAD_HI-DATA_W -: ADDR_W];
    assign phyad_hit = !PHYAD_MATCH || (hdr_phyad == PHY_ADDR);

    assign mdio.mdio_in    = in_oe & rd_shift[DATA_W-1];
    assign mdio.mdio_in_oe = in_oe;

    mdio_regfile #(
        .REG_RST (REG_RST)
    ) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .we         (wr_stb),
        .waddr      (wr_addr),
        .wdata      (wr_data),
        .frame_addr (regad),
        .frame_data (frame_rdata),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mdc_q     <= 1'b0;
            count     <= '0;
            shreg     <= '0;
            regad     <= '0;
            rd_shift  <= '0;
            rd_load   <= 1'b0;
            in_oe     <= 1'b0;
            busy      <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            mdc_q     <= mdio.mdc;
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;
            rd_load   <= 1'b0;

            // Load lands on the fall cycle after bit 15, so bit 16 is stable before its rise
            if (rd_load) begin
                rd_shift <= frame_rdata;
            end else if (fall) begin
                rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
            end

            if (rise) begin
                unique case (state)
                    IDLE: begin
                        if (mdio.mdio_oe && (mdio.mdio_out == ST_CODE[1])) begin
                            state <= ST;
                            count <= 6'd1;
                            busy  <= 1'b1;
                            shreg <= sh_next;
                        end
                    end
                    ST: begin
                        if (!mdio.mdio_oe || (mdio.mdio_out != ST_CODE[0])) begin
                            state     <= ERR;
                            frame_err <= 1'b1;
                            count     <= '0;
                        end else begin
                            state <= HDR;
                            count <= count + 6'd1;
                            shreg <= sh_next;
                        end
                    end
                    HDR: begin
                        if (!mdio.mdio_oe) begin
                            state     <= ERR;
                            frame_err <= 1'b1;
                            count     <= '0;
                        end else begin
                            count <= count + 6'd1;
                            shreg <= sh_next;
                            if (count == 6'(HDR_LEN - 1)) begin
                                regad <= hdr_regad;
                                if (!phyad_hit) begin
                                    state <= IGNORE;
                                end else if (hdr_op == OP_WRITE) begin
                                    state <= WDATA;
                                end else if (hdr_op == OP_READ) begin
                                    state   <= RDATA;
                                    in_oe   <= 1'b1;
                                    rd_load <= 1'b1;
                                end else begin
                                    state     <= ERR;
                                    frame_err <= 1'b1;
                                    count     <= '0;
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (!mdio.mdio_oe) begin
                            state     <= ERR;
                            frame_err <= 1'b1;
                            count     <= '0;
                        end else begin
                            count <= count + 6'd1;
                            shreg <= sh_next;
                            if (count == 6'(FRAME_LEN - 1)) begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                                count   <= '0;
                                wr_stb  <= 1'b1;
                                wr_addr <= regad;
                                wr_data <= sh_next;
                            end
                        end
                    end
                    RDATA: begin
                        if (mdio.mdio_oe) begin
                            state     <= ERR;
                            frame_err <= 1'b1;
                            in_oe     <= 1'b0;
                            count     <= '0;
                        end else begin
                            count <= count + 6'd1;
                            if (count == 6'(FRAME_LEN - 1)) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                in_oe <= 1'b0;
                                count <= '0;
                            end
                        end
                    end
                    ERR, IGNORE: begin
                        if (!mdio.mdio_oe) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            count <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        in_oe <= 1'b0;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule
